// File: rtl/stream_demux.sv
// stream_demux: 1:2 valid/ready stream router with a one-entry output register per channel.
// Define STREAM_DEMUX_COUNT_EN to add the delivered-word counters a_count/b_count.
module stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);
  logic a_free, b_free, in_fire, a_load, b_load;
  assign a_free   = !a_valid || a_ready;
  assign b_free   = !b_valid || b_ready;
  assign in_ready = rst_n && (in_sel ? b_free : a_free);
  assign in_fire  = in_valid && in_ready;
  assign a_load   = in_fire && !in_sel;
  assign b_load   = in_fire && in_sel;
  // A load on the same edge as a drain keeps valid high, so there is no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_data  <= '0;
      b_data  <= '0;
    end else begin
      a_valid <= a_load || (a_valid && !a_ready);
      b_valid <= b_load || (b_valid && !b_ready);
      if (a_load) a_data <= in_data;
      if (b_load) b_data <= in_data;
    end
  end
`ifdef STREAM_DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_valid && a_ready) a_count <= a_count + 16'd1;
      if (b_valid && b_ready) b_count <= b_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: randomized and directed stimulus against a queue-based reference model.
module tb_stream_demux;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sel = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         a_valid, b_valid;
  logic         a_ready = 1'b0;
  logic         b_ready = 1'b0;
  logic [W-1:0] a_data, b_data;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0]  a_count, b_count;
`endif
  int checks = 0;
  int errors = 0;

  stream_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
`ifdef STREAM_DEMUX_COUNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: each channel is a queue of at most one word; counts are delivered words mod 2^16.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int  cnt_a = 0, cnt_b = 0;
  bit  armed = 0, a_zero = 1, b_zero = 1;

  always @(negedge clk) begin
    bit exp_rdy, a_out, b_out;
    exp_rdy = rst_n && (in_sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready));
    a_out = qa.size() != 0 && a_ready;
    b_out = qb.size() != 0 && b_ready;
    if (armed) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
      chk("b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
      if (qa.size() != 0) chk("a_data", {24'b0, a_data}, {24'b0, qa[0]});
      else if (a_zero) chk("a_data_rst", {24'b0, a_data}, 32'h0);
      if (qb.size() != 0) chk("b_data", {24'b0, b_data}, {24'b0, qb[0]});
      else if (b_zero) chk("b_data_rst", {24'b0, b_data}, 32'h0);
`ifdef STREAM_DEMUX_COUNT_EN
      chk("a_count", {16'b0, a_count}, cnt_a);
      chk("b_count", {16'b0, b_count}, cnt_b);
`endif
    end
    if (!rst_n) begin
      armed = 1;
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
      a_zero = 1;
      b_zero = 1;
    end else begin
      if (a_out) begin
        void'(qa.pop_front());
        cnt_a = (cnt_a + 1) % 65536;
      end
      if (b_out) begin
        void'(qb.pop_front());
        cnt_b = (cnt_b + 1) % 65536;
      end
      if (in_valid && exp_rdy) begin
        if (in_sel) begin
          qb.push_back(in_data);
          b_zero = 0;
        end else begin
          qa.push_back(in_data);
          a_zero = 0;
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input bit s, input logic [W-1:0] d,
                     input bit ar, input bit br);
    rst_n = r;
    in_valid = v;
    in_sel = s;
    in_data = d;
    a_ready = ar;
    b_ready = br;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2;
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 1, 1, 8'hEE, 1, 1);
    // Basic route to A
    cyc(1, 1, 0, 8'h3C, 1, 1);
    cyc(1, 0, 1, 8'h99, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    // B backpressure while A keeps flowing
    cyc(1, 1, 1, 8'hA5, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 8'hFF, 1, 0);
    cyc(1, 1, 0, 8'h11, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    // Back-to-back into B
    cyc(1, 1, 1, 8'h01, 1, 1);
    cyc(1, 1, 1, 8'h02, 1, 1);
    cyc(1, 1, 1, 8'h03, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    // Reset while A holds a stalled word
    cyc(1, 1, 0, 8'h7E, 0, 1);
    cyc(1, 0, 0, 8'h00, 0, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    // Idle with toggling sel/data
    for (int i = 0; i < 10; i++) cyc(1, 0, i[0], W'($urandom), $urandom_range(0, 1) == 1, 1);
    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
`ifdef STREAM_DEMUX_COUNT_EN
    // Counter wrap on A: 65536 deliveries bring a_count back to 0
    cyc(0, 0, 0, 8'h00, 1, 1);
    cyc(1, 1, 1, 8'h55, 1, 1);
    for (int i = 0; i < 65537; i++) cyc(1, 1, 0, W'($urandom), 1, 0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    cyc(1, 0, 0, 8'h00, 1, 1);
`endif
    cyc(1, 0, 0, 8'h00, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both outputs.
REQ-002 Ports (one per line: name, direction, width, meaning):
  clk       input   1      single clock, all state on rising edge
  rst_n     input   1      synchronous, active-low reset
  in_valid  input   1      upstream word present
  in_ready  output  1      demux accepts word this cycle
  in_sel    input   1      destination: 0 -> channel A, 1 -> channel B
  in_data   input   WIDTH  upstream word
  a_valid   output  1      channel A word present
  a_ready   input   1      channel A consumer accepts
  a_data    output  WIDTH  channel A word
  b_valid   output  1      channel B word present
  b_ready   input   1      channel B consumer accepts
  b_data    output  WIDTH  channel B word
  a_count   output  16     channel A delivered-word count (STREAM_DEMUX_COUNT_EN only)
  b_count   output  16     channel B delivered-word count (STREAM_DEMUX_COUNT_EN only)
REQ-003 Clock: one clock, clk; reset: rst_n, synchronous, active-low.

Function
REQ-004 Routing SHALL be the inverse of the 2:1 mux: in_sel=0 delivers to A, in_sel=1 delivers to B; the other channel is never written.
REQ-005 Each channel SHALL hold a one-entry output register (x_valid, x_data).
REQ-006 Input transfer occurs when in_valid && in_ready at a rising clk edge.
REQ-007 in_ready SHALL equal (!a_valid || a_ready) when in_sel=0, and (!b_valid || b_ready) when in_sel=1; combinational on in_sel and the ready inputs.
REQ-008 Latency: a word transferred at edge N SHALL appear on x_data with x_valid=1 after edge N, one cycle.
REQ-009 Output transfer occurs when x_valid && x_ready; x_valid clears after that edge unless a new word loads the same channel at the same edge.
REQ-010 Simultaneous drain and load on one channel: x_valid stays 1, x_data takes the new word, no bubble, no loss.
REQ-011 While x_valid=1 and x_ready=0, x_data and x_valid SHALL hold stable.
REQ-012 Channels SHALL drain independently; a stalled A SHALL NOT block words routed to B.
REQ-013 in_sel and in_data are sampled only on a transfer; changes without a transfer have no effect.
REQ-014 in_valid=0 SHALL never modify either channel register.

Reset
REQ-015 With rst_n=0 at a rising edge: a_valid=0, b_valid=0, a_data=0, b_data=0, counters=0.
REQ-016 Reset mid-operation SHALL discard buffered words; no output handshake is counted on that edge.
REQ-017 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-018 Macro STREAM_DEMUX_COUNT_EN: when defined, a_count/b_count ports exist; each increments by 1 per output transfer on its channel, wraps 16'hFFFF -> 16'h0000.
REQ-019 Without STREAM_DEMUX_COUNT_EN: count ports and logic absent; all other behaviour identical.

Verification
REQ-020 Basic route: in_sel=0, in_data=8'h3C, a_ready=1 -> a_valid=1, a_data=8'h3C one cycle later; b_valid stays 0.
REQ-021 Backpressure: load 8'hA5 to B, b_ready=0 for 4 cycles -> b_data=8'hA5 stable, in_ready=0 while in_sel=1; in_sel=0 word 8'h11 still reaches A.
REQ-022 Back-to-back: in_sel=1, words 8'h01,8'h02,8'h03 on consecutive cycles, b_ready=1 -> B emits 01,02,03 on consecutive cycles, no gaps.
REQ-023 Reset mid-stream: a_valid=1 holding 8'h7E, a_ready=0, rst_n=0 one edge -> a_valid=0, a_data=0, a_count unchanged at 0 from reset.
REQ-024 Counter wrap (COUNT_EN): preload via 65535 A transfers, one more -> a_count=16'h0000, b_count unaffected.
REQ-025 Idle: in_valid=0 with in_sel/in_data toggling 10 cycles -> both valids stay 0.
